mem_access_stage: RTL and testbench
===================================

# mem_access_stage

- Pipeline MEM stage: sits between the EX/MEM register and the MEM/WB register.
- Converts load/store control from EX/MEM into requests on a variable-latency data-memory port, with a req/ack handshake.
- Stalls the pipeline until the access completes, then extracts, aligns and sign-extends load data.
- Presents write-back control, load data, ALU result and destination register to MEM/WB.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in WAIT before a bus error (only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- WB_in  in  2  write-back control from EX/MEM
- MemRead_in  in  1  load request
- MemWrite_in  in  1  store request
- size_in  in  2  access size: 00 byte, 01 half, 10 word (11 treated as word)
- sign_ext_in  in  1  sign-extend byte/half loads
- ALU_in  in  32  ALU result and effective address
- wdata_in  in  32  store data, right-justified
- rd_in  in  5  destination register
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_be  out  4  byte enables, little-endian
- mem_wdata  out  32  store data replicated across lanes
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  32  read data, valid with mem_ack
- WB_out  out  2  to MEM/WB
- ReadData_out  out  32  aligned load data to MEM/WB
- ALU_out  out  32  ALU_in passed through
- rd_out  out  5  rd_in passed through
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; MEM/WB is loaded normally
- misalign_err  out  1  misaligned-access flag, combinational
- bus_err  out  1  timeout flag

## Operation
- FSM states: IDLE, WAIT, DONE.
- access = MemRead_in | MemWrite_in; aligned = byte, or half with addr[0]=0, or word with addr[1:0]=0.
- Transitions:
  - IDLE, access & aligned → WAIT. Latch mem_addr, mem_we, mem_be, mem_wdata; set mem_req=1.
  - IDLE, access & !aligned → stay IDLE. misalign_err=1, WB_out=0, ReadData_out=0, no request, stall_out=0.
  - IDLE, no access → stay IDLE. Pass-through, ReadData_out=0.
  - WAIT, mem_ack → DONE. Latch extracted load data (0 for stores) and clear mem_req at the same edge.
  - DONE → IDLE unconditionally.
- stall_out = (IDLE & access & aligned) | WAIT.
- Byte enables:
  - byte: 1 << addr[1:0]
  - half: 0011 or 1100 by addr[1]
  - word: 1111
- Store data: byte replicated ×4, half replicated ×2.
- Load extraction: lane selected by addr[1:0] (byte) or addr[1] (half). Zero- or sign-extended to 32 per sign_ext_in; word loads pass unchanged.
- In DONE: ReadData_out = latched data; WB_out, ALU_out and rd_out follow the inputs.
- Upstream holds all *_in stable while stall_out=1.
- mem_ack outside WAIT is ignored.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata = 0
  - latched read data = 0; bus_err = 0
- Reset during WAIT aborts the access; any later mem_ack is ignored.
- Minimum access, with ack in the first WAIT cycle:
  - cycle 0: IDLE, stall=1
  - cycle 1: WAIT, req=1, ack=1
  - cycle 2: DONE, stall=0
  - MEM/WB captures at the end of cycle 2.
- Latency is 3 cycles plus (n−1) for ack in WAIT cycle n; stall spans cycles 0..n.
- mem_req falls on the edge that ends the ack cycle; there are no back-to-back requests without an IDLE cycle.
- Back-to-back memory instructions: the second one is seen in IDLE the cycle after DONE.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter cleared on IDLE→WAIT increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: WAIT→DONE, mem_req drops, bus_err=1 in DONE, WB_out=0, ReadData_out=0.
  - An ack on the timeout cycle wins: normal completion, no error.
- MEM_TIMEOUT_EN undefined: no counter; WAIT persists until ack; bus_err tied 0.

## Test plan
- Word load, addr 0x100, mem_rdata 0xDEADBEEF, ack in first WAIT cycle → stall high 2 cycles, ReadData_out=0xDEADBEEF in DONE, mem_be=1111.
- Signed byte load, addr 0x103, rdata 0x80123456 → mem_be=1000, ReadData_out=0xFFFFFF80; unsigned → 0x00000080.
- Half store, addr 0x202, wdata 0x0000ABCD, ack after 4 WAIT cycles → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD held for all 4 cycles, stall high 5 cycles.
- Word load at 0x101 → misalign_err=1, no mem_req, stall_out=0, WB_out=0.
- Reset asserted mid-WAIT, then a stray ack → mem_req=0 immediately, state IDLE, ack ignored, all outputs at reset values.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack → DONE after 16 WAIT cycles, bus_err=1, WB_out=0; ack on cycle 16 instead → normal completion, bus_err=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns EX/MEM load/store control into req/ack data-memory accesses,
// stalls until completion and aligns load data. Optional bus timeout under `MEM_TIMEOUT_EN`.
`timescale 1ns/1ps
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  WB_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  size_in,
  input  logic        sign_ext_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  WB_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALU_out,
  output logic [4:0]  rd_out,
  output logic        stall_out,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [31:0] rdata_q;
  logic        bus_err_q;
  logic        access;
  logic        aligned;
  logic        start;
  logic        timeout;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // Select the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] sz,
                                          input logic [1:0] a, input logic sx);
    logic [31:0] sh;
    logic [31:0] r;
    sh = d >> {a, 3'b000};
    case (sz)
      2'b00:   r = {{24{sx & sh[7]}}, sh[7:0]};
      2'b01:   r = a[1] ? {{16{sx & d[31]}}, d[31:16]} : {{16{sx & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    access  = MemRead_in | MemWrite_in;
    aligned = 1'b1;
    be_c    = 4'b1111;
    wdata_c = wdata_in;
    case (size_in)
      2'b00: begin
        be_c    = 4'b0001 << ALU_in[1:0];
        wdata_c = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        aligned = ~ALU_in[0];
        be_c    = ALU_in[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata_in[15:0]}};
      end
      default: aligned = (ALU_in[1:0] == 2'b00);
    endcase
    start = (state == IDLE) & access & aligned;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  // Counts WAIT cycles without ack; the final cycle times out unless ack arrives on it.
  assign timeout = (state == WAIT) & ~mem_ack & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         cnt <= '0;
    else if (start)                     cnt <= '0;
    else if (state == WAIT && !mem_ack) cnt <= cnt + CNT_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus_err_q <= 1'b0;
          if (start) begin
            state     <= WAIT;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite_in;
            mem_addr  <= {ALU_in[31:2], 2'b00};
            mem_be    <= be_c;
            mem_wdata <= wdata_c;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            rdata_q <= mem_we ? 32'd0 : extract(mem_rdata, size_in, ALU_in[1:0], sign_ext_in);
          end else if (timeout) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          bus_err_q <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB sees a bubble while stalled or on a faulted access.
  assign stall_out    = start | (state == WAIT);
  assign misalign_err = (state == IDLE) & access & ~aligned;
  assign WB_out       = (stall_out | misalign_err | ((state == DONE) & bus_err_q)) ? 2'b00 : WB_in;
  assign ReadData_out = ((state == DONE) & ~bus_err_q) ? rdata_q : 32'd0;
  assign ALU_out      = ALU_in;
  assign rd_out       = rd_in;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage with a byte-addressed reference memory
// and a variable-latency memory responder.
`timescale 1ns/1ps
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  WB_in = '0;
  logic        MemRead_in = 1'b0, MemWrite_in = 1'b0, sign_ext_in = 1'b0;
  logic [1:0]  size_in = '0;
  logic [31:0] ALU_in = '0, wdata_in = '0;
  logic [4:0]  rd_in = '0;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  WB_out;
  logic [31:0] ReadData_out, ALU_out;
  logic [4:0]  rd_out;
  logic        stall_out, misalign_err, bus_err;

  logic        resp_en = 1'b1, resp_ack = 1'b0, stray_ack = 1'b0;
  logic [31:0] resp_rdata = '0, stray_rdata = '0;
  assign mem_ack   = resp_ack | stray_ack;
  assign mem_rdata = stray_ack ? stray_rdata : resp_rdata;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .WB_in(WB_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .size_in(size_in), .sign_ext_in(sign_ext_in),
    .ALU_in(ALU_in), .wdata_in(wdata_in), .rd_in(rd_in), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .WB_out(WB_out),
    .ReadData_out(ReadData_out), .ALU_out(ALU_out), .rd_out(rd_out),
    .stall_out(stall_out), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] wb; logic [31:0] data; logic [31:0] alu; logic [4:0] rd; logic mis; } exp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;

  exp_t        exp_q[$];
  req_t        req_q[$];
  logic [7:0]  ref_mem [1024];
  logic [31:0] bus_mem [256];
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
    bus_mem[addr[9:2]] = val;
    for (int j = 0; j < 4; j++) ref_mem[{addr[9:2], 2'b00} + j] = val[8*j +: 8];
  endtask

  // Issue one instruction at posedge+1, record expectations, hold until MEM/WB captures it.
  task automatic issue(input int kind, input logic [1:0] sz, input logic sx, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [1:0] wb, input logic [4:0] rdst);
    exp_t e; req_t r; int n; int a; int cyc; logic [31:0] v;
    WB_in = wb; MemRead_in = (kind == 1); MemWrite_in = (kind == 2); size_in = sz;
    sign_ext_in = sx; ALU_in = alu; wdata_in = wd; rd_in = rdst;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a = int'(alu[9:0]);
    e = '{wb: wb, data: 32'd0, alu: alu, rd: rdst, mis: 1'b0};
    if (kind != 0) begin
      if ((a % n) != 0) begin
        e.wb = 2'b00; e.mis = 1'b1;
      end else begin
        r.addr = alu & ~32'd3; r.we = (kind == 2); r.be = '0; r.wdata = '0;
        for (int j = 0; j < n; j++) r.be[(a % 4) + j] = 1'b1;
        for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
        v = '0;
        if (kind == 1) begin
          for (int j = 0; j < n; j++) v = v | (32'(ref_mem[a + j]) << (8 * j));
          if (sx && n < 4 && v[8*n - 1]) v = v | (~32'd0 << (8 * n));
          e.data = v;
        end else begin
          for (int j = 0; j < n; j++) ref_mem[a + j] = wd[8*j +: 8];
        end
        req_q.push_back(r);
      end
    end
    exp_q.push_back(e);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (stall_out && cyc < 64);
    if (stall_out) check("stall_bound", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: every unstalled cycle MEM/WB captures one instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && !stall_out && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wb_out", 32'(WB_out), 32'(e.wb));
        check("read_data", ReadData_out, e.data);
        check("alu_out", ALU_out, e.alu);
        check("rd_out", 32'(rd_out), 32'(e.rd));
        check("misalign", 32'(misalign_err), 32'(e.mis));
        check("bus_err", 32'(bus_err), 32'd0);
      end
    end
  end

  // Memory responder: checks the request every cycle it is held, acks after random latency.
  initial begin
    req_t r; int lat; logic [7:0] idx;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (resp_en && reset && mem_req) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", 32'(mem_req), 32'd0);
          r = '{addr: mem_addr, we: mem_we, be: mem_be, wdata: mem_wdata};
        end else r = req_q.pop_front();
        lat = $urandom_range(1, 4);
        for (int k = 1; k <= lat; k++) begin
          if (k > 1) @(negedge clk);
          check("req_held", 32'(mem_req), 32'd1);
          check("req_addr", mem_addr, r.addr);
          check("req_we", 32'(mem_we), 32'(r.we));
          check("req_be", 32'(mem_be), 32'(r.be));
          check("req_wdata", mem_wdata, r.wdata);
        end
        idx = mem_addr[9:2];
        resp_rdata = bus_mem[idx];
        if (mem_we)
          for (int i = 0; i < 4; i++) if (mem_be[i]) bus_mem[idx][8*i +: 8] = mem_wdata[8*i +: 8];
        resp_ack = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) set_word(32'(i * 4), $urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", ReadData_out, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    set_word(32'h100, 32'hDEADBEEF);
    issue(1, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 2'b11, 5'd3);
    set_word(32'h100, 32'h80123456);
    issue(1, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 2'b01, 5'd4);
    issue(1, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 2'b01, 5'd5);
    issue(2, 2'd1, 1'b0, 32'h0000_0202, 32'h0000ABCD, 2'b00, 5'd0);
    issue(1, 2'd1, 1'b1, 32'h0000_0202, 32'h0, 2'b10, 5'd6);
    issue(1, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 2'b11, 5'd7);
    issue(0, 2'd0, 1'b0, 32'h1234_5678, 32'h0, 2'b10, 5'd8);

    for (int i = 0; i < 200; i++)
      issue($urandom_range(0, 2), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
            2'($urandom), 5'($urandom));
    WB_in = '0; MemRead_in = 1'b0; MemWrite_in = 1'b0;

    // Reset in the middle of WAIT, followed by a stray ack.
    resp_en = 1'b0;
    MemRead_in = 1'b1; size_in = 2'd2; ALU_in = 32'h0000_0100;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!mem_req && cyc < 8);
    check("abort_req_seen", 32'(mem_req), 32'd1);
    MemRead_in = 1'b0; ALU_in = '0;
    reset = 1'b0;
    #1;
    check("abort_req", 32'(mem_req), 32'd0);
    check("abort_be", 32'(mem_be), 32'd0);
    check("abort_addr", mem_addr, 32'd0);
    check("abort_stall", 32'(stall_out), 32'd0);
    check("abort_rdata", ReadData_out, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    stray_rdata = 32'hCAFEF00D; stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stray_req", 32'(mem_req), 32'd0);
      check("stray_rdata", ReadData_out, 32'd0);
      check("stray_stall", 32'(stall_out), 32'd0);
    end

`ifdef MEM_TIMEOUT_EN
    // No ack: DONE after 16 WAIT cycles with bus_err; then ack on the 16th cycle wins.
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk); #1;
      WB_in = 2'b11; MemRead_in = 1'b1; size_in = 2'd2; ALU_in = 32'h0000_0100;
      stray_rdata = 32'h0BADF00D;
      cyc = 0;
      @(negedge clk);
      while (!mem_req && cyc < 4) begin @(negedge clk); cyc++; end
      cyc = 0;
      while (mem_req && cyc < 40) begin
        cyc++;
        if (pass == 1 && cyc == 16) stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
      end
      check("to_wait_cycles", 32'(cyc), 32'd16);
      check("to_bus_err", 32'(bus_err), (pass == 0) ? 32'd1 : 32'd0);
      check("to_wb", 32'(WB_out), (pass == 0) ? 32'd0 : 32'd3);
      check("to_rdata", ReadData_out, (pass == 0) ? 32'd0 : 32'h0BADF00D);
      @(posedge clk); #1;
      WB_in = '0; MemRead_in = 1'b0;
    end
`endif

    @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
